// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction classes,
// MIPS opcode/funct values and small class helpers.
package mc_pkg;

  localparam int MC_OPC_W   = 6;
  localparam int MC_FN_W    = 6;
  localparam int MC_TMO_W   = 8;
  localparam int MC_TMO_CYC = 200;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP    = 4'd0,
    CL_R_ADD  = 4'd1,
    CL_R_ADDU = 4'd2,
    CL_R_SUB  = 4'd3,
    CL_R_SUBU = 4'd4,
    CL_ADDI   = 4'd5,
    CL_ADDIU  = 4'd6,
    CL_LW     = 4'd7,
    CL_SW     = 4'd8,
    CL_BEQ    = 4'd9,
    CL_J      = 4'd10,
    CL_ILL    = 4'd11
  } class_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;

  localparam logic [1:0] JMP_PC4    = 2'd0;
  localparam logic [1:0] JMP_TARGET = 2'd1;
  localparam logic [1:0] JMP_BRANCH = 2'd2;

  function automatic logic isRClass(input class_t c);
    return c inside {CL_R_ADD, CL_R_ADDU, CL_R_SUB, CL_R_SUBU};
  endfunction

  // Only the signed arithmetic forms trap on overflow.
  function automatic logic hasOvfCheck(input class_t c);
    return c inside {CL_R_ADD, CL_R_SUB, CL_ADDI};
  endfunction

  function automatic logic usesImm(input class_t c);
    return c inside {CL_ADDI, CL_ADDIU, CL_LW, CL_SW};
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction classifier: {opcode,funct} -> instruction class.
// Anything outside the supported subset is reported as CL_ILL.
module mc_decoder
  import mc_pkg::*;
#(
  parameter int OPC_W = MC_OPC_W,
  parameter int FN_W  = MC_FN_W
) (
  input  logic [OPC_W+FN_W-1:0] i_instrCode,
  output logic [3:0]            o_class
);

  logic [OPC_W-1:0] w_opcode;
  logic [FN_W-1:0]  w_funct;

  assign w_opcode = i_instrCode[OPC_W+FN_W-1:FN_W];
  assign w_funct  = i_instrCode[FN_W-1:0];

  always_comb begin
    o_class = CL_ILL;
    case (w_opcode)
      OPC_W'(OP_RTYPE): begin
        case (w_funct)
          FN_W'(FN_ADD):  o_class = CL_R_ADD;
          FN_W'(FN_ADDU): o_class = CL_R_ADDU;
          FN_W'(FN_SUB):  o_class = CL_R_SUB;
          FN_W'(FN_SUBU): o_class = CL_R_SUBU;
          default:        o_class = CL_ILL;
        endcase
      end
      OPC_W'(OP_ADDI):  o_class = CL_ADDI;
      OPC_W'(OP_ADDIU): o_class = CL_ADDIU;
      OPC_W'(OP_LW):    o_class = CL_LW;
      OPC_W'(OP_SW):    o_class = CL_SW;
      OPC_W'(OP_BEQ):   o_class = CL_BEQ;
      OPC_W'(OP_J):     o_class = CL_J;
      default:          o_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset main controller (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout.
// Define MC_ILLEGAL_TRAP_EN to send illegal instructions to a HALT state that only reset leaves.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPC_W   = MC_OPC_W,
  parameter int FN_W    = MC_FN_W,
  parameter int TMO_W   = MC_TMO_W,
  parameter int TMO_CYC = MC_TMO_CYC
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [OPC_W+FN_W-1:0] i_instrCode,
  input  logic                  i_mem_ready,
  output logic                  o_pcWrite,
  output logic                  o_pcWriteCond,
  output logic                  o_irWrite,
  output logic                  o_iorD,
  output logic                  o_memRead,
  output logic                  o_memWrite,
  output logic                  o_regDst,
  output logic                  o_memToReg,
  output logic                  o_ExtOp,
  output logic                  o_aluSrc,
  output logic                  o_regWrite,
  output logic [1:0]            o_jump,
  output logic                  o_branch,
  output logic                  o_memErr,
  output logic [2:0]            o_state
);

  state_t           r_state;
  class_t           r_class;
  logic [TMO_W-1:0] r_waitCnt;
  logic             r_active;

  state_t           w_nextState;
  logic [TMO_W-1:0] w_nextCnt;
  logic [3:0]       w_class;
  class_t           w_decClass;
  logic             w_memPhase;
  logic             w_timeout;

  mc_decoder #(
    .OPC_W(OPC_W),
    .FN_W (FN_W)
  ) u_decoder (
    .i_instrCode(i_instrCode),
    .o_class    (w_class)
  );

  assign w_decClass = class_t'(w_class);
  assign w_memPhase = r_active && ((r_state == ST_FETCH) || (r_state == ST_MEM));
  // The 200th consecutive cycle without ready times out unless ready shows up on it.
  assign w_timeout  = w_memPhase && !i_mem_ready && (r_waitCnt == TMO_W'(TMO_CYC - 1));
  assign w_nextCnt  = (w_memPhase && !i_mem_ready && !w_timeout) ? r_waitCnt + TMO_W'(1) : '0;

  // r_active keeps every output low during reset and for the cycle in which it is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_FETCH;
      r_class   <= CL_NOP;
      r_waitCnt <= '0;
      r_active  <= 1'b0;
    end else begin
      r_active  <= 1'b1;
      r_state   <= w_nextState;
      r_waitCnt <= w_nextCnt;
      if (r_state == ST_DECODE) begin
        r_class <= w_decClass;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (r_active) begin
      case (r_state)
        ST_FETCH:  if (i_mem_ready) w_nextState = ST_DECODE;
        ST_DECODE: begin
          if (w_decClass == CL_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
            w_nextState = ST_HALT;
`else
            w_nextState = ST_FETCH;
`endif
          end else begin
            w_nextState = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (r_class)
            CL_BEQ, CL_J: w_nextState = ST_FETCH;
            CL_LW, CL_SW: w_nextState = ST_MEM;
            CL_R_ADD, CL_R_ADDU, CL_R_SUB, CL_R_SUBU,
            CL_ADDI, CL_ADDIU: w_nextState = ST_WB;
            default:      w_nextState = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (i_mem_ready) begin
            w_nextState = (r_class == CL_LW) ? ST_WB : ST_FETCH;
          end else if (w_timeout) begin
            w_nextState = ST_FETCH;
          end
        end
        ST_WB:   w_nextState = ST_FETCH;
        ST_HALT: w_nextState = ST_HALT;
        default: w_nextState = ST_FETCH;
      endcase
    end
  end

  // Datapath controls come from state and class; only the fetch load strobes and the
  // timeout pulse look at i_mem_ready, since they mark the completing cycle itself.
  always_comb begin
    o_pcWrite     = 1'b0;
    o_pcWriteCond = 1'b0;
    o_irWrite     = 1'b0;
    o_iorD        = 1'b0;
    o_memRead     = 1'b0;
    o_memWrite    = 1'b0;
    o_regDst      = 1'b0;
    o_memToReg    = 1'b0;
    o_ExtOp       = 1'b0;
    o_aluSrc      = 1'b0;
    o_regWrite    = 1'b0;
    o_jump        = JMP_PC4;
    o_branch      = 1'b0;
    o_memErr      = 1'b0;
    if (r_active) begin
      case (r_state)
        ST_FETCH: begin
          o_memRead = 1'b1;
          o_irWrite = i_mem_ready;
          o_pcWrite = i_mem_ready;
          o_memErr  = w_timeout;
        end
        ST_EXEC: begin
          o_aluSrc = usesImm(r_class);
          o_ExtOp  = usesImm(r_class) || (r_class == CL_BEQ);
          o_branch = hasOvfCheck(r_class);
          if (r_class == CL_BEQ) begin
            o_jump        = JMP_BRANCH;
            o_pcWriteCond = 1'b1;
          end else if (r_class == CL_J) begin
            o_jump    = JMP_TARGET;
            o_pcWrite = 1'b1;
          end
        end
        ST_MEM: begin
          o_iorD     = 1'b1;
          o_memRead  = (r_class == CL_LW);
          o_memWrite = (r_class == CL_SW);
          o_memErr   = w_timeout;
        end
        ST_WB: begin
          o_regWrite = 1'b1;
          o_regDst   = isRClass(r_class);
          o_memToReg = (r_class == CL_LW);
        end
        default: ;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases plus a random instruction stream
// checked cycle by cycle against a per-instruction phase model.
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       pcW;
    logic       pcWC;
    logic       irW;
    logic       iorD;
    logic       mR;
    logic       mW;
    logic       rDst;
    logic       m2r;
    logic       ext;
    logic       aSrc;
    logic       rW;
    logic [1:0] jmp;
    logic       br;
    logic       err;
  } outs_t;

  logic        i_clk       = 1'b0;
  logic        i_rst_n     = 1'b1;
  logic [11:0] i_instrCode = '0;
  logic        i_mem_ready = 1'b0;
  logic        o_pcWrite, o_pcWriteCond, o_irWrite, o_iorD, o_memRead, o_memWrite;
  logic        o_regDst, o_memToReg, o_ExtOp, o_aluSrc, o_regWrite, o_branch, o_memErr;
  logic [1:0]  o_jump;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;
  outs_t w_obs;

  multicycle_control dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_instrCode  (i_instrCode),
    .i_mem_ready  (i_mem_ready),
    .o_pcWrite    (o_pcWrite),
    .o_pcWriteCond(o_pcWriteCond),
    .o_irWrite    (o_irWrite),
    .o_iorD       (o_iorD),
    .o_memRead    (o_memRead),
    .o_memWrite   (o_memWrite),
    .o_regDst     (o_regDst),
    .o_memToReg   (o_memToReg),
    .o_ExtOp      (o_ExtOp),
    .o_aluSrc     (o_aluSrc),
    .o_regWrite   (o_regWrite),
    .o_jump       (o_jump),
    .o_branch     (o_branch),
    .o_memErr     (o_memErr),
    .o_state      (o_state)
  );

  assign w_obs = {o_state, o_pcWrite, o_pcWriteCond, o_irWrite, o_iorD, o_memRead, o_memWrite,
                  o_regDst, o_memToReg, o_ExtOp, o_aluSrc, o_regWrite, o_jump, o_branch, o_memErr};

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input outs_t exp, input string tag);
    checks++;
    assert (w_obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, w_obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic [11:0] code, input outs_t exp,
                               input string tag);
    @(negedge i_clk);
    i_mem_ready = rdy;
    i_instrCode = code;
    #1;
    checkOutput(exp, tag);
  endtask

  function automatic logic [11:0] junk();
    return 12'($urandom);
  endfunction

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic doReset(input string tag);
    outs_t z;
    z = '0;
    i_rst_n = 1'b0;
    #1 checkOutput(z, {tag, "_asserted"});
    @(negedge i_clk);
    i_mem_ready = 1'b1;
    #1 checkOutput(z, {tag, "_held"});
    i_rst_n = 1'b1;
    #1 checkOutput(z, {tag, "_released"});
  endtask

  // A memory phase: `waits` cycles without ready, then one with ready. Every 200th consecutive
  // idle cycle must pulse memErr; fetch retries in place, a data access is abandoned.
  task automatic waitPhase(input outs_t busy, input outs_t done, input int waits, input bit retry,
                           input string tag, output bit aborted);
    outs_t e;
    int cnt;
    cnt = 0;
    aborted = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      if (k < waits) begin
        e = busy;
        e.err = (cnt == 199);
        applyStimulus(1'b0, junk(), e, tag);
        if (cnt == 199) begin
          cnt = 0;
          if (!retry) begin
            aborted = 1'b1;
            return;
          end
        end else begin
          cnt++;
        end
      end else begin
        applyStimulus(1'b1, junk(), done, {tag, "_done"});
      end
    end
  endtask

  task automatic runInstr(input int opc, input int fn, input int fWait, input int mWait);
    logic [11:0] code;
    bit isR, isAdd, isSub, isAddi, isAddiu, isLw, isSw, isBeq, isJ, legal, aborted;
    outs_t busy, done, e;
    code    = {6'(opc), 6'(fn)};
    isR     = (opc == 0) && (fn >= 32) && (fn <= 35);
    isAdd   = isR && (fn == 32);
    isSub   = isR && (fn == 34);
    isAddi  = (opc == 8);
    isAddiu = (opc == 9);
    isLw    = (opc == 35);
    isSw    = (opc == 43);
    isBeq   = (opc == 4);
    isJ     = (opc == 2);
    legal   = isR || isAddi || isAddiu || isLw || isSw || isBeq || isJ;

    busy = '0; busy.mR = 1'b1;
    done = busy; done.irW = 1'b1; done.pcW = 1'b1;
    waitPhase(busy, done, fWait, 1'b1, "fetch", aborted);

    e = '0; e.st = 3'd1;
    applyStimulus(rndBit(), code, e, "decode");

    if (!legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
      e = '0; e.st = 3'd5;
      for (int k = 0; k < 4; k++) applyStimulus(rndBit(), junk(), e, "halt");
      doReset("halt_rst");
`endif
      return;
    end

    e = '0; e.st = 3'd2;
    e.aSrc = isAddi || isAddiu || isLw || isSw;
    e.ext  = e.aSrc || isBeq;
    e.jmp  = isBeq ? 2'd2 : (isJ ? 2'd1 : 2'd0);
    e.pcWC = isBeq;
    e.pcW  = isJ;
    e.br   = isAdd || isSub || isAddi;
    applyStimulus(rndBit(), junk(), e, "exec");
    if (isBeq || isJ) return;

    if (isLw || isSw) begin
      busy = '0; busy.st = 3'd3; busy.iorD = 1'b1; busy.mR = isLw; busy.mW = isSw;
      waitPhase(busy, busy, mWait, 1'b0, "mem", aborted);
      if (aborted || isSw) return;
    end

    e = '0; e.st = 3'd4; e.rW = 1'b1; e.rDst = isR; e.m2r = isLw;
    applyStimulus(rndBit(), junk(), e, "wb");
  endtask

  initial begin
    int opTab[12] = '{0, 0, 0, 0, 8, 9, 35, 43, 4, 2, 63, 17};
    int opc, fn, fw, mw;
    outs_t e;
    $display("[TB] multicycle_control bench starting");
    #1 doReset("reset");

    runInstr(0, 32, 0, 0);
    runInstr(35, 0, 0, 3);
    runInstr(4, 0, 0, 0);
    runInstr(2, 0, 0, 0);
    runInstr(63, 0, 0, 0);
    runInstr(0, 35, 0, 0);
    runInstr(0, 32, 205, 0);
    runInstr(35, 0, 0, 200);
    runInstr(43, 0, 0, 199);
    runInstr(0, 36, 1, 0);
    runInstr(9, 5, 2, 0);

    // Reset asserted in the middle of a store's memory wait.
    e = '0; e.mR = 1'b1; e.irW = 1'b1; e.pcW = 1'b1;
    applyStimulus(1'b1, junk(), e, "sw_fetch");
    e = '0; e.st = 3'd1;
    applyStimulus(1'b1, {6'd43, 6'd0}, e, "sw_decode");
    e = '0; e.st = 3'd2; e.aSrc = 1'b1; e.ext = 1'b1;
    applyStimulus(1'b1, junk(), e, "sw_exec");
    e = '0; e.st = 3'd3; e.iorD = 1'b1; e.mW = 1'b1;
    applyStimulus(1'b0, junk(), e, "sw_mem");
    #1 doReset("sw_rst");
    runInstr(8, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      opc = opTab[$urandom_range(0, 11)];
      fn  = (opc == 0) ? int'($urandom_range(30, 37)) : int'($urandom_range(0, 63));
      fw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      mw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      runInstr(opc, fn, fw, mw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
